// File: rtl/move_buffer.sv
// Move-descriptor FIFO between the SPI message handler and the stepper timing engine.
// Optional sticky underrun output is enabled by defining MOVE_BUFFER_UNDERRUN_EN.
module move_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_dir,
  input  logic [WIDTH-1:0] wr_duration,
  input  logic [WIDTH-1:0] wr_increment,
  input  logic [WIDTH-1:0] wr_incinc,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_dir,
  output logic [WIDTH-1:0] rd_duration,
  output logic [WIDTH-1:0] rd_increment,
  output logic [WIDTH-1:0] rd_incinc,
  output logic [LW-1:0]    level,
  output logic             overflow
`ifdef MOVE_BUFFER_UNDERRUN_EN
  ,
  output logic             underrun
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + 3 * WIDTH;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Handshake flags depend only on the registered count, never on wr_valid/rd_ready.
  assign wr_ready = (r_count != LW'(DEPTH));
  assign rd_valid = (r_count != '0);
  assign level    = r_count;
  assign overflow = r_overflow;

  assign w_push = wr_valid && wr_ready && !clear;
  assign w_pop  = rd_valid && rd_ready && !clear;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_dir, wr_duration, wr_increment, wr_incinc};
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (wr_valid && !wr_ready) r_overflow <= 1'b1;
    end
  end

  // Stale entries are masked so the engine never sees an old move while empty.
  assign w_head = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign rd_dir       = w_head[EW-1];
  assign rd_duration  = w_head[3*WIDTH-1:2*WIDTH];
  assign rd_increment = w_head[2*WIDTH-1:WIDTH];
  assign rd_incinc    = w_head[WIDTH-1:0];

`ifdef MOVE_BUFFER_UNDERRUN_EN
  logic r_pop_d;
  logic r_underrun;

  // Underrun: the engine finished a move last cycle and now asks for a successor that is not there.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_pop_d    <= 1'b0;
      r_underrun <= 1'b0;
    end else if (clear) begin
      r_pop_d    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pop_d <= w_pop;
      if (rd_ready && (r_count == '0) && r_pop_d) r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`endif

endmodule

// File: tb/tb_move_buffer.sv
// Scoreboard bench for move_buffer: accepted pushes queue expected moves, a monitor
// checks every read handshake against the queue; directed checks cover flags and level.
module tb_move_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int EW    = 1 + 3 * WIDTH;

  logic             CLK;
  logic             resetn;
  logic             clear;
  logic             wr_valid;
  logic             wr_ready;
  logic             wr_dir;
  logic [WIDTH-1:0] wr_duration;
  logic [WIDTH-1:0] wr_increment;
  logic [WIDTH-1:0] wr_incinc;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_dir;
  logic [WIDTH-1:0] rd_duration;
  logic [WIDTH-1:0] rd_increment;
  logic [WIDTH-1:0] rd_incinc;
  logic [LW-1:0]    level;
  logic             overflow;
`ifdef MOVE_BUFFER_UNDERRUN_EN
  logic             underrun;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  move_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .resetn(resetn), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dir(wr_dir),
    .wr_duration(wr_duration), .wr_increment(wr_increment), .wr_incinc(wr_incinc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dir(rd_dir),
    .rd_duration(rd_duration), .rd_increment(rd_increment), .rd_incinc(rd_incinc),
    .level(level), .overflow(overflow)
`ifdef MOVE_BUFFER_UNDERRUN_EN
    , .underrun(underrun)
`endif
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic idle();
    wr_valid     = 1'b0;
    rd_ready     = 1'b0;
    clear        = 1'b0;
    wr_dir       = 1'b0;
    wr_duration  = '0;
    wr_increment = '0;
    wr_incinc    = '0;
  endtask

  task automatic set_push(input logic dir, input logic [63:0] dur, input logic [63:0] inc,
                          input logic [63:0] incinc, input bit accept);
    wr_valid     = 1'b1;
    wr_dir       = dir;
    wr_duration  = dur;
    wr_increment = inc;
    wr_incinc    = incinc;
    if (accept) exp_q.push_back({dir, dur, inc, incinc});
  endtask

  task automatic push_one(input logic [63:0] dur);
    set_push(dur[0], dur, dur + 64'd7, ~dur, 1'b1);
    tick();
    idle();
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    idle();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: compares every accepted read against the expected queue
  always @(negedge CLK) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    if (resetn && !clear && rd_valid && rd_ready) begin
      got = {rd_dir, rd_duration, rd_increment, rd_incinc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual_dur=%0d required=none", rd_duration);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pop_data actual_dur=%0d inc=%0h dir=%0b required_dur=%0d inc=%0h dir=%0b",
                   rd_duration, rd_increment, rd_dir,
                   exp[3*WIDTH-1:2*WIDTH], exp[2*WIDTH-1:WIDTH], exp[EW-1]);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_rd_duration", rd_duration, 64'd0);
    resetn = 1'b1;
    tick();

    // Basic flow
    set_push(1'b1, 64'd100, 64'd5, {64{1'b1}}, 1'b1);
    tick();
    idle();
    check("basic_rd_valid", 64'(rd_valid), 64'd1);
    check("basic_rd_duration", rd_duration, 64'd100);
    check("basic_rd_incinc", rd_incinc, {64{1'b1}});
    check("basic_level", 64'(level), 64'd1);
    rd_ready = 1'b1;
    tick();
    idle();
    check("basic_after_pop_valid", 64'(rd_valid), 64'd0);
    check("basic_after_pop_level", 64'(level), 64'd0);
    check("basic_after_pop_dur_zero", rd_duration, 64'd0);
    check("basic_after_pop_inc_zero", rd_increment, 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) push_one(64'(i));
    check("full_wr_ready", 64'(wr_ready), 64'd0);
    check("full_level", 64'(level), 64'd4);
    check("full_overflow_clear", 64'(overflow), 64'd0);
    set_push(1'b0, 64'd5, 64'd0, 64'd0, 1'b0);
    tick();
    idle();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_level", 64'(level), 64'd4);
    drain(4);
    check("ovf_drained_valid", 64'(rd_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Simultaneous push/pop at level 2
    push_one(64'd20);
    push_one(64'd21);
    set_push(1'b0, 64'd22, 64'd1, 64'd2, 1'b1);
    rd_ready = 1'b1;
    tick();
    check("pp2_level_a", 64'(level), 64'd2);
    set_push(1'b1, 64'd23, 64'd3, 64'd4, 1'b1);
    tick();
    idle();
    check("pp2_level_b", 64'(level), 64'd2);
    drain(2);

    // Clear resets overflow
    clear = 1'b1;
    tick();
    idle();
    check("clr_overflow_a", 64'(overflow), 64'd0);

    // Push+pop while full: pop happens, push dropped
    for (int i = 30; i <= 33; i++) push_one(64'(i));
    set_push(1'b0, 64'd34, 64'd0, 64'd0, 1'b0);
    rd_ready = 1'b1;
    tick();
    idle();
    check("ppfull_level", 64'(level), 64'd3);
    check("ppfull_overflow", 64'(overflow), 64'd1);
    drain(3);

    // Pointer wrap: 10 entries through a level-2 pipeline
    push_one(64'd10);
    push_one(64'd11);
    for (int i = 12; i <= 19; i++) begin
      set_push(1'b0, 64'(i), 64'(i * 3), 64'(i + 100), 1'b1);
      rd_ready = 1'b1;
      tick();
    end
    idle();
    check("wrap_level", 64'(level), 64'd2);
    drain(2);

    // Clear together with a push at level 3
    push_one(64'd40);
    push_one(64'd41);
    push_one(64'd42);
    check("preclr_level", 64'(level), 64'd3);
    clear = 1'b1;
    set_push(1'b0, 64'd43, 64'd0, 64'd0, 1'b0);
    exp_q.delete();
    tick();
    idle();
    check("clr_level", 64'(level), 64'd0);
    check("clr_overflow_b", 64'(overflow), 64'd0);
    check("clr_rd_valid", 64'(rd_valid), 64'd0);

    // Asynchronous reset between edges at level 2
    push_one(64'd50);
    push_one(64'd51);
    check("prerst_level", 64'(level), 64'd2);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_level", 64'(level), 64'd0);
    check("async_rst_valid", 64'(rd_valid), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    push_one(64'd60);
    drain(1);

`ifdef MOVE_BUFFER_UNDERRUN_EN
    push_one(64'd70);
    rd_ready = 1'b1;
    tick();
    check("udr_before", 64'(underrun), 64'd0);
    tick();
    idle();
    check("udr_set", 64'(underrun), 64'd1);
    tick();
    check("udr_held", 64'(underrun), 64'd1);
    clear = 1'b1;
    tick();
    idle();
    check("udr_cleared", 64'(underrun), 64'd0);
    check("udr_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
